// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit -- iterative RV32M multiply/divide execution unit.
//
// Computes one of the eight M-extension operations with a radix-2 datapath
// (shift-add multiply, restoring divide). Each operation takes 34 cycles from
// accepted start to the done pulse. The result, destination index and write
// enable drive the register-file write port.
//
// Optional feature: define MULDIV_EARLY_OUT_EN to let divide-by-zero, signed
// divide overflow and multiply-by-zero finish in one cycle. Results are
// identical in both builds; only latency changes.
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous, active-low reset
//   start   in   1  request a new operation (honoured only in IDLE)
//   funct3  in   3  000 MUL 001 MULH 010 MULHSU 011 MULHU
//                   100 DIV 101 DIVU 110 REM 111 REMU
//   op_a    in  32  rs1 value (multiplicand / dividend)
//   op_b    in  32  rs2 value (multiplier / divisor)
//   rd_in   in   5  destination register index
//   busy    out  1  high whenever the unit is not IDLE
//   done    out  1  one-cycle pulse, result/rd_out valid
//   result  out 32  operation result, held until overwritten
//   rd_out  out  5  latched destination index
//   we_out  out  1  register-file write enable (done and rd_out != 0)
// -----------------------------------------------------------------------------
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        we_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      3'b001, 3'b010, 3'b100, 3'b110: s = 1'b1;
      default:                        s = 1'b0;
    endcase
    return s;
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      3'b001, 3'b100, 3'b110: s = 1'b1;
      default:                s = 1'b0;
    endcase
    return s;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [2:0]  f3_r;
  logic [31:0] mag_a_r, mag_b_r;
  logic        sgn_a_r, sgn_b_r;
  logic [63:0] acc_r;
  logic [4:0]  cnt_r;

  logic        sgn_a_s, sgn_b_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic        early_s;
  logic [31:0] early_res_s;
  logic [4:0]  rd_nxt_s;

  logic [63:0] mul_addend_s, mul_acc_s;
  logic        div_bit_s, div_ge_s;
  logic [32:0] div_trial_s, div_diff_s;
  logic [31:0] div_rem_s;
  logic [63:0] div_acc_s, step_acc_s;

  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s, fix_res_s;

  // Operand magnitudes and signs as captured when a start is accepted.
  always_comb begin
    sgn_a_s = a_is_signed(funct3) & op_a[31];
    sgn_b_s = b_is_signed(funct3) & op_b[31];
    mag_a_s = sgn_a_s ? neg32(op_a) : op_a;
    mag_b_s = sgn_b_s ? neg32(op_b) : op_b;
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Special cases whose answer is known from the raw operands.
  always_comb begin
    early_s     = 1'b0;
    early_res_s = 32'd0;
    if (funct3[2] && (op_b == 32'd0)) begin
      early_s     = 1'b1;
      early_res_s = funct3[1] ? op_a : 32'hFFFF_FFFF;
    end else if (!funct3[0] && funct3[2] && (op_a == 32'h8000_0000) &&
                 (op_b == 32'hFFFF_FFFF)) begin
      early_s     = 1'b1;
      early_res_s = funct3[1] ? 32'd0 : 32'h8000_0000;
    end else if (!funct3[2] && ((op_a == 32'd0) || (op_b == 32'd0))) begin
      early_s     = 1'b1;
      early_res_s = 32'd0;
    end else begin
      early_s     = 1'b0;
      early_res_s = 32'd0;
    end
  end
`else
  // Every operation runs the full iterative path.
  always_comb begin
    early_s     = 1'b0;
    early_res_s = 32'd0;
  end
`endif

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = early_s ? DONE : CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == 5'd31) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:     state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Destination index as it will be held after this edge (for we_out).
  always_comb begin
    if ((state_r == IDLE) && start) begin
      rd_nxt_s = rd_in;
    end else begin
      rd_nxt_s = rd_out;
    end
  end

  // One radix-2 step. Multiply adds the shifted multiplicand for each set
  // multiplier bit. Divide keeps remainder in acc[63:32] and builds the
  // quotient in acc[31:0], feeding dividend bits in MSB first.
  always_comb begin
    mul_addend_s = mag_b_r[cnt_r] ? ({32'd0, mag_a_r} << cnt_r) : 64'd0;
    mul_acc_s    = acc_r + mul_addend_s;

    div_bit_s    = mag_a_r[5'd31 - cnt_r];
    div_trial_s  = {acc_r[63:32], div_bit_s};
    div_diff_s   = div_trial_s - {1'b0, mag_b_r};
    div_ge_s     = ~div_diff_s[32];
    // When the subtract fails the trial is below the divisor, so 32 bits hold it.
    div_rem_s    = div_ge_s ? div_diff_s[31:0] : div_trial_s[31:0];
    div_acc_s    = {div_rem_s, acc_r[30:0], div_ge_s};

    step_acc_s   = f3_r[2] ? div_acc_s : mul_acc_s;
  end

  // Sign correction and result selection.
  always_comb begin
    prod_s = (sgn_a_r ^ sgn_b_r) ? neg64(acc_r) : acc_r;
    if (mag_b_r == 32'd0) begin
      // Divide by zero: quotient is all ones regardless of dividend sign.
      quot_s = 32'hFFFF_FFFF;
    end else begin
      quot_s = (sgn_a_r ^ sgn_b_r) ? neg32(acc_r[31:0]) : acc_r[31:0];
    end
    rem_s = sgn_a_r ? neg32(acc_r[63:32]) : acc_r[63:32];
    case (f3_r)
      3'b000:                 fix_res_s = prod_s[31:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_s[63:32];
      3'b100, 3'b101:         fix_res_s = quot_s;
      3'b110, 3'b111:         fix_res_s = rem_s;
      default:                fix_res_s = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      f3_r    <= 3'd0;
      mag_a_r <= 32'd0;
      mag_b_r <= 32'd0;
      sgn_a_r <= 1'b0;
      sgn_b_r <= 1'b0;
      acc_r   <= 64'd0;
      cnt_r   <= 5'd0;
      result  <= 32'd0;
      rd_out  <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      we_out  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            f3_r    <= funct3;
            mag_a_r <= mag_a_s;
            mag_b_r <= mag_b_s;
            sgn_a_r <= sgn_a_s;
            sgn_b_r <= sgn_b_s;
            acc_r   <= 64'd0;
            cnt_r   <= 5'd0;
            rd_out  <= rd_in;
            if (early_s) begin
              result <= early_res_s;
            end
          end
        end
        CALC: begin
          acc_r <= step_acc_s;
          cnt_r <= cnt_r + 5'd1;
        end
        FIX: begin
          result <= fix_res_s;
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
      busy   <= (state_nxt_s != IDLE);
      done   <= (state_nxt_s == DONE);
      we_out <= (state_nxt_s == DONE) && (rd_nxt_s != 5'd0);
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit -- directed self-checking bench for muldiv_unit.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 34;
`endif
  localparam int LAT_FULL = 34;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .we_out (we_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble the inputs after acceptance, wait for done
  // and check latency, result, destination, write enable and the return to idle.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input logic exp_we, input int exp_lat);
    int lat;
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk); #1;
    lat = 1;
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    rd_in = 5'($urandom); funct3 = 3'($urandom);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    chk({tag, " we_out"}, 32'(we_out), 32'(exp_we));
    @(posedge clk); #1;
    chk({tag, " done_drop"}, 32'(done), 32'd0);
    chk({tag, " we_drop"}, 32'(we_out), 32'd0);
    chk({tag, " busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    rst = 1'b0; start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset we", 32'(we_out), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd", 32'(rd_out), 32'd0);
    @(negedge clk); rst = 1'b1;

    do_op("mul_7x6", 3'b000, 32'd7, 32'd6, 5'd5, 32'h0000_002A, 1'b1, LAT_FULL);
    do_op("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 5'd2, 32'hFFFF_FFF1, 1'b1, LAT_FULL);
    do_op("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 1'b1, LAT_FULL);
    do_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b1, LAT_FULL);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd31, 32'hFFFF_FFFF, 1'b1, LAT_FULL);
    do_op("mul_zero", 3'b000, 32'd0, 32'd123, 5'd6, 32'd0, 1'b1, LAT_SPECIAL);
    do_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 1'b1, LAT_FULL);
    do_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 1'b1, LAT_FULL);
    do_op("div_20_m6", 3'b100, 32'd20, 32'hFFFF_FFFA, 5'd9, 32'hFFFF_FFFD, 1'b1, LAT_FULL);
    do_op("rem_20_m6", 3'b110, 32'd20, 32'hFFFF_FFFA, 5'd9, 32'd2, 1'b1, LAT_FULL);
    do_op("divu_by0", 3'b101, 32'd100, 32'd0, 5'd10, 32'hFFFF_FFFF, 1'b1, LAT_SPECIAL);
    do_op("remu_by0", 3'b111, 32'd100, 32'd0, 5'd10, 32'd100, 1'b1, LAT_SPECIAL);
    do_op("div_neg_by0", 3'b100, 32'hFFFF_FFFB, 32'd0, 5'd11, 32'hFFFF_FFFF, 1'b1, LAT_SPECIAL);
    do_op("rem_neg_by0", 3'b110, 32'hFFFF_FFFB, 32'd0, 5'd11, 32'hFFFF_FFFB, 1'b1, LAT_SPECIAL);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b1, LAT_SPECIAL);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1'b1, LAT_SPECIAL);

    // Start pulses during CALC and during the DONE cycle must be ignored.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd12; op_b = 32'd11; rd_in = 5'd7;
    @(posedge clk); #1;
    lat = 1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b1; funct3 = 3'b100; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd20;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    chk("ign_calc busy", 32'(busy), 32'd1);
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_calc latency", 32'(lat), 32'd34);
    chk("ign_calc result", result, 32'h0000_0084);
    chk("ign_calc rd_out", 32'(rd_out), 32'd7);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5; rd_in = 5'd3;
    @(posedge clk); #1;
    chk("ign_done busy", 32'(busy), 32'd0);
    chk("ign_done done", 32'(done), 32'd0);
    chk("ign_done result", result, 32'h0000_0084);
    chk("ign_done rd_out", 32'(rd_out), 32'd7);
    start = 1'b0;
    @(posedge clk); #1;
    chk("ign_done still_idle", 32'(busy), 32'd0);
    do_op("mul_after_ign", 3'b000, 32'd5, 32'd5, 5'd3, 32'd25, 1'b1, LAT_FULL);

    // Reset asserted while the counter holds 15 discards the operation.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst we", 32'(we_out), 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst rd", 32'(rd_out), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || we_out === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("midrst no_pulse", 32'(pulses), 32'd0);
    do_op("divu_9_3", 3'b101, 32'd9, 32'd3, 5'd4, 32'd3, 1'b1, LAT_FULL);

    do_op("mul_rd0", 3'b000, 32'd3, 32'd3, 5'd0, 32'd9, 1'b0, LAT_FULL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
